// File: rtl/wait_state_mem_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wait_state_mem_responder_if                                      |
// | Request/response bundle between a memory requester and responder |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface wait_state_mem_responder_if;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [3:0]  be;
  logic [31:0] data_in;
  logic        new_request;
  logic [31:0] data_out;
  logic        data_valid;
  logic        ready;

  modport master (
    output addr, re, we, be, data_in, new_request,
    input  data_out, data_valid, ready
  );

  modport slave (
    input  addr, re, we, be, data_in, new_request,
    output data_out, data_valid, ready
  );
endinterface
`default_nettype wire

// File: rtl/wait_state_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wait_state_mem_responder                                         |
// | Fixed-latency word memory responder with per-byte write enables. |
// | Define WAIT_STATE_RESPONDER_RANGE_CHECK_EN to suppress accesses   |
// | outside BASE_ADDR..BASE_ADDR+4*DEPTH_WORDS-1 instead of aliasing. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module wait_state_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  wait_state_mem_responder_if.slave  bus
);

  localparam int unsigned      c_IDXW = $clog2(DEPTH_WORDS);
  localparam int unsigned      c_CNTW = 4;
  localparam logic [c_CNTW-1:0] c_LOAD = c_CNTW'(LATENCY - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNTW-1:0]  r_cnt;
  logic [c_CNTW-1:0]  w_cnt_nxt;

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [31:0]        r_data_out;
  logic               r_data_valid;

  logic [c_IDXW-1:0]  r_idx;
  logic               r_we;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic               r_ok;

  logic               w_accept;
  logic               w_fire;
  logic [c_IDXW-1:0]  w_in_idx;
  logic               w_in_ok;
  logic [c_IDXW-1:0]  w_op_idx;
  logic               w_op_we;
  logic [3:0]         w_op_be;
  logic [31:0]        w_op_wdata;
  logic               w_op_ok;

  assign w_accept = (r_state == S_IDLE) && bus.new_request && (bus.re || bus.we);
  assign w_in_idx = c_IDXW'((bus.addr - BASE_ADDR) >> 2);

`ifdef WAIT_STATE_RESPONDER_RANGE_CHECK_EN
  assign w_in_ok = (64'(bus.addr) >= 64'(BASE_ADDR)) &&
                   (64'(bus.addr) <  64'(BASE_ADDR) + 64'(4) * 64'(DEPTH_WORDS));
`else
  assign w_in_ok = 1'b1;
`endif

  // Single-cycle latency completes on the accepting edge, so operands
  // come straight from the bus instead of the capture registers.
  always_comb begin
    w_op_idx   = r_idx;
    w_op_we    = r_we;
    w_op_be    = r_be;
    w_op_wdata = r_wdata;
    w_op_ok    = r_ok;
    if (LATENCY == 1) begin
      w_op_idx   = w_in_idx;
      w_op_we    = bus.we;
      w_op_be    = bus.be;
      w_op_wdata = bus.data_in;
      w_op_ok    = w_in_ok;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_fire = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_LOAD;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - c_CNTW'(1);
        if (w_cnt_nxt == '0) begin
          w_fire      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_wdata <= 32'h0;
      r_ok    <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= w_in_idx;
      r_we    <= bus.we;
      r_be    <= bus.be;
      r_wdata <= bus.data_in;
      r_ok    <= w_in_ok;
    end
  end

  // Storage is deliberately outside reset; rst only blocks a completing write.
  always_ff @(posedge clk) begin
    if (!rst && w_fire && w_op_we && w_op_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (w_op_be[i]) begin
          r_mem[w_op_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_valid <= 1'b0;
      r_data_out   <= 32'h0;
    end else begin
      r_data_valid <= w_fire && !w_op_we;
      if (w_fire && !w_op_we) begin
        r_data_out <= w_op_ok ? r_mem[w_op_idx] : 32'h0;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.ready      = (r_state == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wait_state_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wait_state_mem_responder                                      |
// | Directed bench for LATENCY=1, 2 and 4 responder instances.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_wait_state_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wait_state_mem_responder_if if1 ();
  wait_state_mem_responder_if if2 ();
  wait_state_mem_responder_if if4 ();

  wait_state_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  wait_state_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) u_l2 (
    .clk(clk), .rst(rst), .bus(if2)
  );
  wait_state_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .BASE_ADDR(32'h0)) u_l4 (
    .clk(clk), .rst(rst), .bus(if4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic nr, input logic re, input logic we,
                      input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    if1.new_request = nr; if1.re = re; if1.we = we;
    if1.addr = a; if1.be = b; if1.data_in = d;
  endtask

  task automatic drv2(input logic nr, input logic re, input logic we,
                      input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    if2.new_request = nr; if2.re = re; if2.we = we;
    if2.addr = a; if2.be = b; if2.data_in = d;
  endtask

  task automatic drv4(input logic nr, input logic re, input logic we,
                      input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    if4.new_request = nr; if4.re = re; if4.we = we;
    if4.addr = a; if4.be = b; if4.data_in = d;
  endtask

  // Full operations: return in the cycle the operation completes.
  task automatic wr2(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    drv2(1, 0, 1, a, b, d); tick; drv2(0, 0, 0, 0, 0, 0); tick;
  endtask

  task automatic rd2(input logic [31:0] a);
    drv2(1, 1, 0, a, 4'h0, 0); tick; drv2(0, 0, 0, 0, 0, 0); tick;
  endtask

  task automatic wr4(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    drv4(1, 0, 1, a, b, d); tick; drv4(0, 0, 0, 0, 0, 0);
    repeat (3) tick;
  endtask

  task automatic rd4(input logic [31:0] a);
    drv4(1, 1, 0, a, 4'h0, 0); tick; drv4(0, 0, 0, 0, 0, 0);
    repeat (3) tick;
  endtask

  initial begin
    logic [31:0] l1_data [4];
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    l1_data = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
`ifdef WAIT_STATE_RESPONDER_RANGE_CHECK_EN
    exp_hi = 32'h0;
    exp_lo = 32'h0;
`else
    exp_hi = 32'h1234_5678;
    exp_lo = 32'h1234_5678;
`endif

    rst = 1'b1;
    drv1(0, 0, 0, 0, 0, 0);
    drv2(0, 0, 0, 0, 0, 0);
    drv4(0, 0, 0, 0, 0, 0);
    tick; tick;
    rst = 1'b0;
    tick;
    check("rst_ready_l2", if2.ready, 1);
    check("rst_dv_l2",    if2.data_valid, 0);
    check("rst_dout_l2",  if2.data_out, 32'h0);
    check("rst_ready_l1", if1.ready, 1);
    check("rst_ready_l4", if4.ready, 1);

    // Basic write then read, LATENCY=2
    drv2(1, 0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF);
    check("b_ready_t0", if2.ready, 1);
    tick; drv2(0, 0, 0, 0, 0, 0);
    check("b_ready_t1", if2.ready, 0);
    tick;
    check("b_ready_t2", if2.ready, 1);
    check("b_dv_t2", if2.data_valid, 0);
    drv2(1, 1, 0, 32'h10, 4'h0, 0);
    tick; drv2(0, 0, 0, 0, 0, 0);
    check("b_ready_t3", if2.ready, 0);
    check("b_dv_t3", if2.data_valid, 0);
    tick;
    check("b_dv_t4", if2.data_valid, 1);
    check("b_dout_t4", if2.data_out, 32'hDEAD_BEEF);
    check("b_ready_t4", if2.ready, 1);
    tick;
    check("b_dv_t5", if2.data_valid, 0);
    check("b_hold_t5", if2.data_out, 32'hDEAD_BEEF);

    // Partial write merges enabled bytes only
    wr2(32'h20, 4'hF, 32'h1122_3344);
    wr2(32'h20, 4'b0101, 32'hAABB_CCDD);
    rd2(32'h20);
    check("pw_dv", if2.data_valid, 1);
    check("pw_dout", if2.data_out, 32'h11BB_33DD);

    // be=0 write takes full latency and changes nothing
    drv2(1, 0, 1, 32'h20, 4'h0, 32'hFFFF_FFFF);
    tick; drv2(0, 0, 0, 0, 0, 0);
    check("be0_ready_t1", if2.ready, 0);
    tick;
    check("be0_ready_t2", if2.ready, 1);
    check("be0_dv_t2", if2.data_valid, 0);
    rd2(32'h20);
    check("be0_dout", if2.data_out, 32'h11BB_33DD);

    // re and we together act as a write
    drv2(1, 1, 1, 32'h24, 4'hF, 32'h55AA_55AA);
    tick; drv2(0, 0, 0, 0, 0, 0);
    tick;
    check("rw_dv", if2.data_valid, 0);
    rd2(32'h24);
    check("rw_dout", if2.data_out, 32'h55AA_55AA);

    // Back-to-back at LATENCY=1
    for (int k = 0; k < 4; k++) begin
      drv1(1, 0, 1, 32'(4 * k), 4'hF, l1_data[k]);
      tick;
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drv1(1, 1, 0, 32'(4 * k), 4'h0, 0);
      else       drv1(0, 0, 0, 0, 0, 0);
      check($sformatf("l1_ready_%0d", k), if1.ready, 1);
      if (k == 0) begin
        check("l1_dv_0", if1.data_valid, 0);
      end else begin
        check($sformatf("l1_dv_%0d", k), if1.data_valid, 1);
        check($sformatf("l1_dout_%0d", k), if1.data_out, l1_data[k-1]);
      end
      tick;
    end
    check("l1_dv_end", if1.data_valid, 0);

    // Reset during a pending write, LATENCY=4
    wr4(32'h40, 4'hF, 32'h0);
    drv4(1, 0, 1, 32'h40, 4'hF, 32'hCAFE_F00D);
    tick; drv4(0, 0, 0, 0, 0, 0);
    check("rw4_ready_t1", if4.ready, 0);
    tick;
    rst = 1'b1;
    check("rw4_ready_t2", if4.ready, 0);
    tick;
    rst = 1'b0;
    check("rw4_ready_t3", if4.ready, 1);
    check("rw4_dv_t3", if4.data_valid, 0);
    rd4(32'h40);
    check("rw4_rd_dv", if4.data_valid, 1);
    check("rw4_rd_dout", if4.data_out, 32'h0);

    // Ignored requests, LATENCY=4
    wr4(32'h44, 4'hF, 32'h1357_9BDF);
    drv4(1, 0, 0, 32'h44, 4'hF, 32'hFFFF_FFFF);
    tick; drv4(0, 0, 0, 0, 0, 0);
    check("ign_noop_ready", if4.ready, 1);
    check("ign_noop_dv", if4.data_valid, 0);
    drv4(1, 1, 0, 32'h44, 4'h0, 0);
    tick;
    drv4(1, 0, 1, 32'h44, 4'hF, 32'hFFFF_FFFF);
    check("ign_w_ready_t1", if4.ready, 0);
    tick; drv4(0, 0, 0, 0, 0, 0);
    check("ign_w_ready_t2", if4.ready, 0);
    check("ign_w_dv_t2", if4.data_valid, 0);
    tick;
    check("ign_w_ready_t3", if4.ready, 0);
    tick;
    check("ign_w_ready_t4", if4.ready, 1);
    check("ign_w_dv_t4", if4.data_valid, 1);
    check("ign_w_dout_t4", if4.data_out, 32'h1357_9BDF);
    tick;
    check("ign_w_dv_t5", if4.data_valid, 0);
    rd4(32'h44);
    check("ign_mem", if4.data_out, 32'h1357_9BDF);

    // Out-of-range address: aliasing or suppression
    wr2(32'h0, 4'hF, 32'h0);
    wr2(32'h1000, 4'hF, 32'h1234_5678);
    rd2(32'h1000);
    check("rng_hi_dv", if2.data_valid, 1);
    check("rng_hi_dout", if2.data_out, exp_hi);
    rd2(32'h0);
    check("rng_lo_dout", if2.data_out, exp_lo);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wait_state_mem_responder.md
WAIT_STATE_MEM_RESPONDER -- requirements
Module: wait_state_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit storage words; SHALL be a power of two and at least 2.
REQ-002 Parameter LATENCY, default 2, number of cycles from request acceptance to completion; legal range 1..8.
REQ-003 Parameter BASE_ADDR, default 32'h00000000, byte address of word 0.
REQ-004 clk  in  1  sole clock; every register SHALL update on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 addr  in  32  byte address of the request.
REQ-007 re  in  1  read request qualifier.
REQ-008 we  in  1  write request qualifier.
REQ-009 be  in  4  byte enables for writes; be[i] covers bits 8i+7:8i.
REQ-010 data_in  in  32  write data.
REQ-011 new_request  in  1  request strobe, sampled only when ready=1.
REQ-012 data_out  out  32  read data, valid when data_valid=1.
REQ-013 data_valid  out  1  one-cycle read-completion pulse.
REQ-014 ready  out  1  responder can accept a request this cycle.

Function
REQ-015 The block SHALL act as the responder end of the memory sub-unit protocol, backed by internal storage of DEPTH_WORDS words.
REQ-016 Word index SHALL be (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits; addr[1:0] is ignored.
REQ-017 A request SHALL be accepted in cycle t iff ready=1 and new_request=1 and (re or we); addr, we, be and data_in are captured at that point.
REQ-018 new_request with re=0 and we=0 SHALL be ignored, leaving state unchanged.
REQ-019 new_request while ready=0 SHALL be ignored, with no state change.
REQ-020 When re and we are both high, the request SHALL be treated as a write.
REQ-021 FSM states:
  - IDLE: ready=1.
  - WAIT: ready=0; a down-counter is loaded with LATENCY-1 on acceptance.
REQ-022 FSM transitions:
  - IDLE to WAIT on acceptance when LATENCY>1.
  - WAIT to IDLE when the counter reaches 0 and completes.
  - With LATENCY=1 the FSM SHALL remain in IDLE and ready SHALL stay 1.
REQ-023 Read accepted in cycle t:
  - data_valid=1 in exactly cycle t+LATENCY.
  - data_out in that cycle holds the word at the captured index.
  - ready=1 in that same cycle, so a back-to-back request is accepted.
REQ-024 Write accepted in cycle t:
  - Storage SHALL be updated at the clock edge ending cycle t+LATENCY-1, for enabled bytes only.
  - No data_valid pulse is produced.
  - ready=1 in cycle t+LATENCY.
REQ-025 A write with be=4'b0000 SHALL consume LATENCY cycles and modify no storage.
REQ-026 A read accepted in the cycle a write completes SHALL return the newly written data.
REQ-027 data_out SHALL hold its last read value while data_valid=0.
REQ-028 Sustained throughput SHALL be one request per LATENCY cycles.

Reset
REQ-029 While rst=1 the block SHALL force: FSM to IDLE, counter to 0, data_valid=0, data_out=32'h0.
REQ-030 ready SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset during WAIT SHALL drop the pending operation:
  - A pending write SHALL NOT modify storage.
  - A pending read SHALL produce no data_valid.
REQ-032 Storage contents SHALL NOT be cleared by rst.

Configuration
REQ-033 Macro WAIT_STATE_RESPONDER_RANGE_CHECK_EN, when defined, SHALL apply range checking to requests whose addr falls outside BASE_ADDR..BASE_ADDR+4*DEPTH_WORDS-1:
  - Reads SHALL return 32'h0 with normal timing.
  - Writes SHALL be dropped with normal timing.
REQ-034 When WAIT_STATE_RESPONDER_RANGE_CHECK_EN is undefined, out-of-range addresses SHALL alias by index truncation per REQ-016.

Verification
REQ-035 Basic write/read, LATENCY=2:
  - Write addr=0x10, be=4'hF, data=0xDEADBEEF at t=0, then read 0x10 at t=2.
  - Required: data_valid only at t=4 with data_out=0xDEADBEEF; ready=0 at t=1 and t=3.
REQ-036 Partial write:
  - Word 0x20 holds 0x11223344; write be=4'b0101, data=0xAABBCCDD; then read 0x20.
  - Required: read returns 0x11BB33DD.
REQ-037 Back-to-back, LATENCY=1:
  - Four reads on consecutive cycles.
  - Required: ready constantly 1, with four consecutive data_valid pulses each one cycle after its request.
REQ-038 Reset mid-write, LATENCY=4:
  - Write 0xCAFEF00D to 0x40 at t=0 (prior value 0x0); rst=1 at t=2.
  - Required: ready=1 at t=3 and a later read of 0x40 returns 0x0.
REQ-039 Ignored requests:
  - new_request with re=we=0, and new_request during WAIT.
  - Required: no data_valid, no storage change, and the FSM timing of the in-flight operation is unchanged.
REQ-040 Range check, DEPTH_WORDS=1024:
  - Write 0x12345678 to 0x1000; prior value at 0x0 is 0x0; read 0x1000 and read 0x0.
  - With macro: read 0x1000 returns 0x0 and read 0x0 returns its prior value 0x0.
  - Without macro: both reads return 0x12345678.
